// File: rtl/apb_uart_fifo.sv
// APB3 slave UART: 8N1 framing, 16-bit baud divisor, TX/RX FIFOs,
// sticky error flags and a maskable registered level interrupt.
//
// TX FSM
//   state    | meaning
//   TX_IDLE  | line high, waiting for tx_en and a queued byte
//   TX_START | driving the start bit (low)
//   TX_DATA  | shifting out 8 data bits, LSB first
//   TX_STOP  | driving the stop bit (high)
//
// RX FSM
//   state    | meaning
//   RX_IDLE  | waiting for a low level on the synchronised line
//   RX_START | half-bit wait, then confirm the start bit
//   RX_DATA  | sampling 8 data bits at bit centres, LSB first
//   RX_STOP  | sampling the stop bit, then pushing the byte
module apb_uart_fifo #(
    parameter int          TX_DEPTH   = 16,
    parameter int          RX_DEPTH   = 16,
    parameter logic [15:0] DIV_RESET  = 16'd433,
    parameter int          ADDR_WIDTH = 12
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [ADDR_WIDTH-1:0] paddr_i,
    input  logic                  psel_i,
    input  logic                  penable_i,
    input  logic                  pwrite_i,
    input  logic [31:0]           pwdata_i,
    output logic [31:0]           prdata_o,
    output logic                  pready_o,
    output logic                  pslverr_o,
    output logic                  irq_o,
    output logic                  tx_o,
    input  logic                  rx_i
);

    localparam int TXP_W = $clog2(TX_DEPTH);
    localparam int TXC_W = TXP_W + 1;
    localparam int RXP_W = $clog2(RX_DEPTH);
    localparam int RXC_W = RXP_W + 1;
    localparam int IDX_W = ADDR_WIDTH - 2;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    // ---------------- APB decode ----------------
    logic             access;
    logic [IDX_W-1:0] reg_idx;
    logic             idx_data, idx_status, idx_ctrl, idx_div, idx_bad;

    assign access     = psel_i & penable_i;
    assign reg_idx    = paddr_i[ADDR_WIDTH-1:2];
    assign idx_data   = (reg_idx == IDX_W'(0));
    assign idx_status = (reg_idx == IDX_W'(1));
    assign idx_ctrl   = (reg_idx == IDX_W'(2));
    assign idx_div    = (reg_idx == IDX_W'(3));
    assign idx_bad    = (reg_idx > IDX_W'(3));
    assign pready_o   = 1'b1;

    logic unused_bits;
    assign unused_bits = ^{pwdata_i[31:16], paddr_i[1:0]};

    logic [4:0]  ctrl_q;
    logic [15:0] div_q;
    logic        tx_en, rx_en, rx_ie, tx_ie, err_ie;
    assign tx_en  = ctrl_q[0];
    assign rx_en  = ctrl_q[1];
    assign rx_ie  = ctrl_q[2];
    assign tx_ie  = ctrl_q[3];
    assign err_ie = ctrl_q[4];

    // ---------------- TX FIFO ----------------
    logic [7:0]       tx_mem [TX_DEPTH];
    logic [TXP_W-1:0] tx_wr_ptr, tx_rd_ptr;
    logic [TXC_W-1:0] tx_count;
    logic             tx_full, tx_empty, tx_push, tx_pop;
    logic [7:0]       tx_head;

    assign tx_full  = (tx_count == TXC_W'(TX_DEPTH));
    assign tx_empty = (tx_count == '0);
    // full is judged before any same-cycle pop, so a write into a full FIFO is dropped
    assign tx_push  = access & pwrite_i & idx_data & ~tx_full;
    assign tx_head  = tx_mem[tx_rd_ptr];

    // TX FIFO pointers and occupancy
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_count  <= '0;
        end else begin
            if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
            if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
            if (tx_push && !tx_pop)      tx_count <= tx_count + 1'b1;
            else if (tx_pop && !tx_push) tx_count <= tx_count - 1'b1;
        end
    end

    // TX FIFO storage
    always_ff @(posedge clk_i) begin
        if (tx_push) tx_mem[tx_wr_ptr] <= pwdata_i[7:0];
    end

    // ---------------- RX FIFO ----------------
    logic [7:0]       rx_mem [RX_DEPTH];
    logic [RXP_W-1:0] rx_wr_ptr, rx_rd_ptr;
    logic [RXC_W-1:0] rx_count;
    logic             rx_full, rx_empty, rx_push, rx_pop, rx_done;
    logic [7:0]       rx_shift_q, rx_shift_d;
    logic [7:0]       rx_count8;

    assign rx_full   = (rx_count == RXC_W'(RX_DEPTH));
    assign rx_empty  = (rx_count == '0);
    assign rx_push   = rx_done & ~rx_full;
    assign rx_pop    = access & ~pwrite_i & idx_data & ~rx_empty;
    assign rx_count8 = 8'(rx_count);

    // RX FIFO pointers and occupancy
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_count  <= '0;
        end else begin
            if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
            if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
            if (rx_push && !rx_pop)      rx_count <= rx_count + 1'b1;
            else if (rx_pop && !rx_push) rx_count <= rx_count - 1'b1;
        end
    end

    // RX FIFO storage
    always_ff @(posedge clk_i) begin
        if (rx_push) rx_mem[rx_wr_ptr] <= rx_shift_q;
    end

    // ---------------- TX FSM ----------------
    tx_state_t   tx_state_q, tx_state_d;
    logic [15:0] tx_timer_q, tx_timer_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic        tx_tc;

    assign tx_tc = (tx_timer_q == 16'd0);

    // TX state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tx_state_q <= TX_IDLE;
            tx_timer_q <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_timer_q <= tx_timer_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
        end
    end

    // TX next state, FIFO pop and line level; the timer reloads from DIV at every bit boundary
    always_comb begin
        tx_state_d = tx_state_q;
        tx_timer_d = tx_timer_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_pop     = 1'b0;
        tx_o       = 1'b1;
        case (tx_state_q)
            TX_IDLE: begin
                if (tx_en && !tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_shift_d = tx_head;
                    tx_timer_d = div_q;
                    tx_state_d = TX_START;
                end
            end
            TX_START: begin
                tx_o = 1'b0;
                if (tx_tc) begin
                    tx_timer_d = div_q;
                    tx_bit_d   = 3'd0;
                    tx_state_d = TX_DATA;
                end else begin
                    tx_timer_d = tx_timer_q - 16'd1;
                end
            end
            TX_DATA: begin
                tx_o = tx_shift_q[0];
                if (tx_tc) begin
                    tx_timer_d = div_q;
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = TX_STOP;
                    end else begin
                        tx_bit_d   = tx_bit_q + 3'd1;
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    end
                end else begin
                    tx_timer_d = tx_timer_q - 16'd1;
                end
            end
            TX_STOP: begin
                if (tx_tc) begin
                    // chain straight into the next frame so there is no idle gap
                    if (tx_en && !tx_empty) begin
                        tx_pop     = 1'b1;
                        tx_shift_d = tx_head;
                        tx_timer_d = div_q;
                        tx_state_d = TX_START;
                    end else begin
                        tx_state_d = TX_IDLE;
                    end
                end else begin
                    tx_timer_d = tx_timer_q - 16'd1;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // ---------------- RX FSM ----------------
    logic [1:0]  rx_sync_q;
    logic        rx_s;
    rx_state_t   rx_state_q, rx_state_d;
    logic [15:0] rx_timer_q, rx_timer_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic        rx_tc;

    assign rx_s  = rx_sync_q[1];
    assign rx_tc = (rx_timer_q == 16'd0);

    // two-flop synchroniser for the asynchronous serial input
    always_ff @(posedge clk_i) begin
        if (rst_i) rx_sync_q <= 2'b11;
        else       rx_sync_q <= {rx_sync_q[0], rx_i};
    end

    // RX state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_state_q <= RX_IDLE;
            rx_timer_q <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_timer_q <= rx_timer_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
        end
    end

    // RX next state; rx_en only gates the start of a frame so a frame in flight completes
    always_comb begin
        rx_state_d = rx_state_q;
        rx_timer_d = rx_timer_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_done    = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (rx_en && !rx_s) begin
                    rx_timer_d = div_q >> 1;
                    rx_state_d = RX_START;
                end
            end
            RX_START: begin
                if (rx_tc) begin
                    if (!rx_s) begin
                        rx_timer_d = div_q;
                        rx_bit_d   = 3'd0;
                        rx_state_d = RX_DATA;
                    end else begin
                        rx_state_d = RX_IDLE;
                    end
                end else begin
                    rx_timer_d = rx_timer_q - 16'd1;
                end
            end
            RX_DATA: begin
                if (rx_tc) begin
                    rx_shift_d = {rx_s, rx_shift_q[7:1]};
                    rx_timer_d = div_q;
                    if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
                    else                  rx_bit_d   = rx_bit_q + 3'd1;
                end else begin
                    rx_timer_d = rx_timer_q - 16'd1;
                end
            end
            RX_STOP: begin
                if (rx_tc) begin
                    rx_done    = 1'b1;
                    rx_state_d = RX_IDLE;
                end else begin
                    rx_timer_d = rx_timer_q - 16'd1;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // ---------------- registers, flags, interrupt ----------------
    logic overrun_q, frame_err_q, status_wr, tx_busy;

    assign status_wr = access & pwrite_i & idx_status;
    assign tx_busy   = (tx_state_q != TX_IDLE) | ~tx_empty;

    // CTRL/DIV writes and sticky flags; a hardware set beats a same-cycle W1C
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ctrl_q      <= '0;
            div_q       <= DIV_RESET;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            if (access && pwrite_i && idx_ctrl) ctrl_q <= pwdata_i[4:0];
            if (access && pwrite_i && idx_div)  div_q  <= pwdata_i[15:0];
            overrun_q   <= (rx_done & rx_full) | (overrun_q & ~(status_wr & pwdata_i[5]));
            frame_err_q <= (rx_done & ~rx_s)   | (frame_err_q & ~(status_wr & pwdata_i[6]));
        end
    end

    // registered level interrupt
    always_ff @(posedge clk_i) begin
        if (rst_i) irq_o <= 1'b0;
        else       irq_o <= (rx_ie & ~rx_empty) | (tx_ie & tx_empty) |
                            (err_ie & (overrun_q | frame_err_q));
    end

    // read mux and error response from the current cycle's state
    always_comb begin
        prdata_o  = '0;
        pslverr_o = 1'b0;
        if (idx_data) begin
            if (!rx_empty) prdata_o = {24'b0, rx_mem[rx_rd_ptr]};
            pslverr_o = access & pwrite_i & tx_full;
        end else if (idx_status) begin
            prdata_o = {16'b0, rx_count8, 1'b0, frame_err_q, overrun_q, tx_busy,
                        rx_full, rx_empty, tx_empty, tx_full};
        end else if (idx_ctrl) begin
            prdata_o = {27'b0, ctrl_q};
        end else if (idx_div) begin
            prdata_o = {16'b0, div_q};
        end else if (idx_bad) begin
            pslverr_o = access;
        end
    end

endmodule

// File: tb/tb_apb_uart_fifo.sv
// Directed bench for apb_uart_fifo: TX framing, TX FIFO full, RX receive,
// glitch rejection, framing error with interrupt, overrun, and reset mid-frame.
module tb_apb_uart_fifo;

    localparam logic [11:0] A_DATA = 12'h000;
    localparam logic [11:0] A_STAT = 12'h004;
    localparam logic [11:0] A_CTRL = 12'h008;
    localparam logic [11:0] A_DIV  = 12'h00C;
    localparam logic [11:0] A_BAD  = 12'h010;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [11:0] paddr_i = '0;
    logic        psel_i = 1'b0;
    logic        penable_i = 1'b0;
    logic        pwrite_i = 1'b0;
    logic [31:0] pwdata_i = '0;
    logic [31:0] prdata_o;
    logic        pready_o;
    logic        pslverr_o;
    logic        irq_o;
    logic        tx_o;
    logic        rx_i = 1'b1;

    int n_checks = 0;
    int n_errors = 0;

    apb_uart_fifo #(
        .TX_DEPTH  (16),
        .RX_DEPTH  (16),
        .DIV_RESET (16'd433),
        .ADDR_WIDTH(12)
    ) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .paddr_i  (paddr_i),
        .psel_i   (psel_i),
        .penable_i(penable_i),
        .pwrite_i (pwrite_i),
        .pwdata_i (pwdata_i),
        .prdata_o (prdata_o),
        .pready_o (pready_o),
        .pslverr_o(pslverr_o),
        .irq_o    (irq_o),
        .tx_o     (tx_o),
        .rx_i     (rx_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic apb_write(input logic [11:0] addr, input logic [31:0] data, output logic err);
        @(negedge clk_i);
        psel_i = 1'b1; penable_i = 1'b0; pwrite_i = 1'b1; paddr_i = addr; pwdata_i = data;
        @(negedge clk_i);
        penable_i = 1'b1;
        #1 err = pslverr_o;
        @(negedge clk_i);
        psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0;
    endtask

    task automatic apb_read(input logic [11:0] addr, output logic [31:0] data, output logic err);
        @(negedge clk_i);
        psel_i = 1'b1; penable_i = 1'b0; pwrite_i = 1'b0; paddr_i = addr;
        @(negedge clk_i);
        penable_i = 1'b1;
        #1 begin data = prdata_o; err = pslverr_o; end
        @(negedge clk_i);
        psel_i = 1'b0; penable_i = 1'b0;
    endtask

    // one 8N1 frame at 8 clocks per bit, then idle high
    task automatic send_byte(input logic [7:0] d, input logic stop_bit);
        @(negedge clk_i);
        rx_i = 1'b0;
        repeat (8) @(negedge clk_i);
        for (int i = 0; i < 8; i++) begin
            rx_i = d[i];
            repeat (8) @(negedge clk_i);
        end
        rx_i = stop_bit;
        repeat (8) @(negedge clk_i);
        rx_i = 1'b1;
        repeat (12) @(negedge clk_i);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        err;
        logic [39:0] tx_obs;
        logic [7:0]  tx_byte;
        logic [3:0]  grp_exp;
        int          err_cnt;

        // reset state
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        check_val("rst_tx_o", tx_o, 1);
        check_val("rst_irq", irq_o, 0);
        check_val("rst_pready", pready_o, 1);
        apb_read(A_STAT, rd, err);
        check_val("rst_status", rd, 32'h0000_0006);
        apb_read(A_CTRL, rd, err);
        check_val("rst_ctrl", rd, 32'h0);
        apb_read(A_DIV, rd, err);
        check_val("rst_div", rd, 32'd433);

        // out-of-range offset and empty DATA read
        apb_read(A_BAD, rd, err);
        check_val("bad_rd_data", rd, 32'h0);
        check_val("bad_rd_err", err, 1);
        apb_write(A_BAD, 32'hFFFF_FFFF, err);
        check_val("bad_wr_err", err, 1);
        apb_read(A_DATA, rd, err);
        check_val("empty_rd_data", rd, 32'h0);
        check_val("empty_rd_err", err, 0);

        // TX frame 0xA5 at DIV=3
        apb_write(A_DIV, 32'd3, err);
        apb_write(A_CTRL, 32'h1, err);
        tx_byte = 8'hA5;
        apb_write(A_DATA, {24'b0, tx_byte}, err);
        check_val("tx_push_err", err, 0);
        check_val("tx_idle_before_start", tx_o, 1);
        fork
            begin
                for (int k = 0; k < 40; k++) begin
                    @(negedge clk_i);
                    tx_obs[k] = tx_o;
                end
            end
            begin
                repeat (10) @(negedge clk_i);
                apb_read(A_STAT, rd, err);
                check_val("tx_status_busy", rd, 32'h0000_0016);
            end
        join
        for (int g = 0; g < 10; g++) begin
            if (g == 0)      grp_exp = 4'b0000;
            else if (g == 9) grp_exp = 4'b1111;
            else             grp_exp = {4{tx_byte[g-1]}};
            check_val($sformatf("tx_bit%0d", g), {28'b0, tx_obs[4*g +: 4]}, {28'b0, grp_exp});
        end
        apb_read(A_STAT, rd, err);
        check_val("tx_status_done", rd, 32'h0000_0006);

        // RX 0x3C at DIV=7
        apb_write(A_DIV, 32'd7, err);
        apb_write(A_CTRL, 32'h2, err);
        send_byte(8'h3C, 1'b1);
        apb_read(A_STAT, rd, err);
        check_val("rx_status_one", rd, 32'h0000_0102);
        apb_read(A_DATA, rd, err);
        check_val("rx_data_3c", rd, 32'h0000_003C);
        apb_read(A_STAT, rd, err);
        check_val("rx_status_empty", rd, 32'h0000_0006);

        // 2-clock low glitch yields no byte
        @(negedge clk_i);
        rx_i = 1'b0;
        repeat (2) @(negedge clk_i);
        rx_i = 1'b1;
        repeat (30) @(negedge clk_i);
        apb_read(A_STAT, rd, err);
        check_val("rx_glitch_status", rd, 32'h0000_0006);

        // framing error, error interrupt and W1C
        apb_write(A_CTRL, 32'h12, err);
        send_byte(8'h55, 1'b0);
        check_val("ferr_irq_set", irq_o, 1);
        apb_read(A_STAT, rd, err);
        check_val("ferr_status", rd, 32'h0000_0142);
        apb_write(A_STAT, 32'h40, err);
        @(negedge clk_i);
        check_val("ferr_irq_clr", irq_o, 0);
        apb_read(A_DATA, rd, err);
        check_val("ferr_data_55", rd, 32'h0000_0055);
        apb_read(A_STAT, rd, err);
        check_val("ferr_status_clr", rd, 32'h0000_0006);

        // overrun with RX interrupt enabled
        apb_write(A_CTRL, 32'h6, err);
        for (int i = 0; i < 17; i++) send_byte(8'h80 + 8'(i), 1'b1);
        check_val("ovr_irq", irq_o, 1);
        apb_read(A_STAT, rd, err);
        check_val("ovr_status", rd, 32'h0000_102A);
        for (int i = 0; i < 16; i++) begin
            apb_read(A_DATA, rd, err);
            check_val($sformatf("ovr_data%0d", i), rd, 32'h80 + 32'(i));
        end
        repeat (2) @(negedge clk_i);
        check_val("ovr_irq_clr", irq_o, 0);
        apb_read(A_STAT, rd, err);
        check_val("ovr_status_drained", rd, 32'h0000_0026);
        apb_write(A_STAT, 32'h20, err);
        apb_read(A_STAT, rd, err);
        check_val("ovr_w1c", rd, 32'h0000_0006);

        // TX FIFO full with tx_en=0
        apb_write(A_CTRL, 32'h0, err);
        err_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            apb_write(A_DATA, 32'h10 + 32'(i), err);
            if (err) err_cnt++;
        end
        check_val("txf_accept_errs", err_cnt, 0);
        apb_write(A_DATA, 32'hEE, err);
        check_val("txf_17th_err", err, 1);
        apb_read(A_STAT, rd, err);
        check_val("txf_status", rd, 32'h0000_0015);

        // reset for one cycle mid TX frame
        apb_write(A_CTRL, 32'h1, err);
        repeat (30) @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        check_val("rst_mid_tx_o", tx_o, 1);
        apb_read(A_STAT, rd, err);
        check_val("rst_mid_status", rd, 32'h0000_0006);
        apb_read(A_DIV, rd, err);
        check_val("rst_mid_div", rd, 32'd433);
        apb_read(A_CTRL, rd, err);
        check_val("rst_mid_ctrl", rd, 32'h0);
        repeat (10) @(negedge clk_i);
        check_val("rst_mid_tx_idle", tx_o, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
